// File: rtl/fwd_hazard_ctrl_pkg.sv
// Shared types and helpers for the forwarding / load-use hazard controller.
package fwd_hazard_ctrl_pkg;

    localparam int MAX_AW = 8;
    localparam int FWD_RF = 0;

    typedef struct packed {
        logic              valid;
        logic              regwrite;
        logic              memread;
        logic              memwrite;
        logic [MAX_AW-1:0] rd;
        logic [MAX_AW-1:0] src1;
    } tagEntry_t;

    function automatic int selWidth(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic logic tagHit(
        input tagEntry_t         e,
        input logic [MAX_AW-1:0] r,
        input logic              zeroReg
    );
        return e.valid & e.regwrite & (e.rd == r)
             & ~(zeroReg & (r == '0));
    endfunction

endpackage

// File: rtl/fwd_match.sv
// Compares one source register against the youngest DEPTH tag entries and
// returns the nearest producer as a forwarding select.
module fwd_match
    import fwd_hazard_ctrl_pkg::*;
#(
    parameter int REG_AW   = 4,
    parameter int DEPTH    = 2,
    parameter int SELW     = 2,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic [REG_AW-1:0] src,
    input  logic              srcEn,
    input  tagEntry_t         entries [DEPTH],
    output logic [SELW-1:0]   sel,
    output logic              hit0
);

    logic [MAX_AW-1:0] srcExt;

    assign srcExt = MAX_AW'(src);

    // Walk oldest to youngest so the youngest producer overwrites.
    always_comb begin
        sel = SELW'(FWD_RF);
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (srcEn && tagHit(entries[k], srcExt, ZERO_REG)) begin
                sel = SELW'(k + 1);
            end
        end
    end

    assign hit0 = srcEn & tagHit(entries[0], srcExt, ZERO_REG);

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding select, load-use stall and store-data forwarding control,
// driven by a private pipeline of in-flight destination tags.
module fwd_hazard_ctrl
    import fwd_hazard_ctrl_pkg::*;
#(
    parameter  int REG_AW   = 4,
    parameter  int DEPTH    = 2,
    parameter  int NSRC     = 2,
    parameter  bit ZERO_REG = 1'b1,
    localparam int SELW     = selWidth(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   id_valid,
    input  logic                   id_regwrite,
    input  logic                   id_memread,
    input  logic                   id_memwrite,
    input  logic [REG_AW-1:0]      id_rd,
    input  logic [NSRC*REG_AW-1:0] id_src,
    input  logic [NSRC-1:0]        id_src_en,
    input  logic                   flush,
    input  logic                   freeze,
    output logic                   stall_id,
    output logic [NSRC*SELW-1:0]   fwd_sel,
    output logic                   fwd_mem,
    output logic [15:0]            stall_cnt
);

    if (DEPTH < 1 || DEPTH > 6) begin : gBadDepth
        $error("DEPTH must be in 1..6");
    end
    if (NSRC < 2) begin : gBadNsrc
        $error("NSRC must be at least 2");
    end
    if (REG_AW > MAX_AW) begin : gBadAw
        $error("REG_AW exceeds MAX_AW");
    end

    tagEntry_t                tags    [DEPTH+1];
    tagEntry_t                cmpTags [DEPTH];
    tagEntry_t                idTag;
    logic [NSRC-1:0][SELW-1:0] selNext;
    logic [NSRC-1:0][SELW-1:0] selQ;
    logic [NSRC-1:0]          hit0;
    logic                     storeExempt;
    logic                     fwdMemNext;
    logic                     fwdMemQ;
    logic [15:0]              stallCnt;

    always_comb begin
        idTag          = '0;
        idTag.valid    = id_valid;
        idTag.regwrite = id_regwrite;
        idTag.memread  = id_memread;
        idTag.memwrite = id_memwrite;
        idTag.rd       = MAX_AW'(id_rd);
        idTag.src1     = MAX_AW'(id_src[REG_AW +: REG_AW]);
    end

    for (genvar k = 0; k < DEPTH; k++) begin : gCmp
        assign cmpTags[k] = tags[k];
    end

    for (genvar i = 0; i < NSRC; i++) begin : gSrc
        fwd_match #(
            .REG_AW   (REG_AW),
            .DEPTH    (DEPTH),
            .SELW     (SELW),
            .ZERO_REG (ZERO_REG)
        ) uMatch (
            .src     (id_src[i*REG_AW +: REG_AW]),
            .srcEn   (id_src_en[i]),
            .entries (cmpTags),
            .sel     (selNext[i]),
            .hit0    (hit0[i])
        );
    end

    // A store whose only dependency on the load is its data can wait
    // for the MEM-to-MEM path instead of stalling.
    assign storeExempt = id_memwrite & (hit0 == NSRC'(2));

    assign stall_id = id_valid & (|hit0) & tags[0].memread
                    & ~storeExempt & ~freeze;

    assign fwdMemNext = tags[0].valid & tags[0].memwrite
                      & tags[1].memread
                      & tagHit(tags[1], tags[0].src1, ZERO_REG);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k <= DEPTH; k++) begin
                tags[k] <= '0;
            end
            selQ     <= '0;
            fwdMemQ  <= 1'b0;
            stallCnt <= '0;
        end else if (!freeze) begin
            for (int k = DEPTH; k > 0; k--) begin
                tags[k] <= tags[k-1];
            end
            fwdMemQ <= fwdMemNext;
            if (flush || stall_id) begin
                tags[0] <= '0;
                selQ    <= '0;
            end else begin
                tags[0] <= idTag;
                selQ    <= selNext;
            end
            if (stall_id && !flush && stallCnt != 16'hFFFF) begin
                stallCnt <= stallCnt + 16'd1;
            end
        end
    end

    assign fwd_sel   = selQ;
    assign fwd_mem   = fwdMemQ;
    assign stall_cnt = stallCnt;

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Directed vector bench for fwd_hazard_ctrl (REG_AW=4, DEPTH=2, NSRC=2).
module tb_fwd_hazard_ctrl;

    localparam int REG_AW = 4;
    localparam int NSRC   = 2;
    localparam int SELW   = 2;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic                   id_valid;
    logic                   id_regwrite;
    logic                   id_memread;
    logic                   id_memwrite;
    logic [REG_AW-1:0]      id_rd;
    logic [NSRC*REG_AW-1:0] id_src;
    logic [NSRC-1:0]        id_src_en;
    logic                   flush;
    logic                   freeze;
    logic                   stall_id;
    logic [NSRC*SELW-1:0]   fwd_sel;
    logic                   fwd_mem;
    logic [15:0]            stall_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fwd_hazard_ctrl #(
        .REG_AW   (4),
        .DEPTH    (2),
        .NSRC     (2),
        .ZERO_REG (1'b1)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .id_valid    (id_valid),
        .id_regwrite (id_regwrite),
        .id_memread  (id_memread),
        .id_memwrite (id_memwrite),
        .id_rd       (id_rd),
        .id_src      (id_src),
        .id_src_en   (id_src_en),
        .flush       (flush),
        .freeze      (freeze),
        .stall_id    (stall_id),
        .fwd_sel     (fwd_sel),
        .fwd_mem     (fwd_mem),
        .stall_cnt   (stall_cnt)
    );

    typedef struct {
        logic        v, rw, mr, mw;
        logic [3:0]  rd, s0, s1;
        logic [1:0]  en;
        logic        fl, fz;
        logic        eStall;
        logic [1:0]  eSel0, eSel1;
        logic        eMem;
        logic [15:0] eCnt;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(
        int v, int rw, int mr, int mw, int rd, int s0, int s1,
        int en, int fl, int fz,
        int st, int e0, int e1, int em, int cnt
    );
        vec_t r;
        r.v = 1'(v);     r.rw = 1'(rw);   r.mr = 1'(mr);
        r.mw = 1'(mw);   r.rd = 4'(rd);   r.s0 = 4'(s0);
        r.s1 = 4'(s1);   r.en = 2'(en);   r.fl = 1'(fl);
        r.fz = 1'(fz);   r.eStall = 1'(st);
        r.eSel0 = 2'(e0); r.eSel1 = 2'(e1);
        r.eMem = 1'(em); r.eCnt = 16'(cnt);
        return r;
    endfunction

    function automatic vec_t idle(int e0, int e1, int em, int cnt);
        return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, e0, e1, em, cnt);
    endfunction

    task automatic drive(input vec_t t);
        id_valid    = t.v;
        id_regwrite = t.rw;
        id_memread  = t.mr;
        id_memwrite = t.mw;
        id_rd       = t.rd;
        id_src      = {t.s1, t.s0};
        id_src_en   = t.en;
        flush       = t.fl;
        freeze      = t.fz;
    endtask

    task automatic check(input string name,
                         input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic checkRow(input int i, input vec_t t);
        check($sformatf("r%0d stall", i), 32'(stall_id), 32'(t.eStall));
        check($sformatf("r%0d sel0", i), 32'(fwd_sel[1:0]), 32'(t.eSel0));
        check($sformatf("r%0d sel1", i), 32'(fwd_sel[3:2]), 32'(t.eSel1));
        check($sformatf("r%0d mem", i), 32'(fwd_mem), 32'(t.eMem));
        check($sformatf("r%0d cnt", i), 32'(stall_cnt), 32'(t.eCnt));
    endtask

    vec_t lw, sub, add3, rd3;

    initial begin
        // ALU forwarding distances 1, 2 and beyond DEPTH
        vecs.push_back(idle(0, 0, 0, 0));
        vecs.push_back(mk(1, 1, 0, 0, 3, 1, 2, 3, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 1, 0, 0, 6, 3, 7, 3, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 1, 0, 0, 8, 9, 3, 3, 0, 0, 0, 1, 0, 0, 0));
        vecs.push_back(mk(1, 1, 0, 0, 10, 3, 6, 3, 0, 0, 0, 0, 2, 0, 0));
        vecs.push_back(idle(0, 2, 0, 0));
        // load-use stall
        vecs.push_back(mk(1, 1, 1, 0, 5, 2, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 1, 0, 0, 11, 5, 1, 3, 0, 0, 1, 0, 0, 0, 0));
        vecs.push_back(mk(1, 1, 0, 0, 11, 5, 1, 3, 0, 0, 0, 0, 0, 0, 1));
        vecs.push_back(idle(2, 0, 0, 1));
        // store data from load: no stall, MEM-to-MEM
        vecs.push_back(mk(1, 1, 1, 0, 5, 2, 0, 1, 0, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mk(1, 0, 0, 1, 0, 2, 5, 3, 0, 0, 0, 0, 0, 0, 1));
        vecs.push_back(idle(0, 1, 0, 1));
        vecs.push_back(idle(0, 0, 1, 1));
        vecs.push_back(idle(0, 0, 0, 1));
        // store address from load: stalls
        vecs.push_back(mk(1, 1, 1, 0, 5, 2, 0, 1, 0, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mk(1, 0, 0, 1, 0, 5, 1, 3, 0, 0, 1, 0, 0, 0, 1));
        vecs.push_back(mk(1, 0, 0, 1, 0, 5, 1, 3, 0, 0, 0, 0, 0, 0, 2));
        vecs.push_back(idle(2, 0, 0, 2));
        vecs.push_back(idle(0, 0, 0, 2));
        // r0 never forwards nor stalls
        vecs.push_back(mk(1, 1, 0, 0, 0, 1, 2, 3, 0, 0, 0, 0, 0, 0, 2));
        vecs.push_back(mk(1, 1, 0, 0, 12, 0, 0, 3, 0, 0, 0, 0, 0, 0, 2));
        vecs.push_back(mk(1, 1, 0, 0, 13, 0, 12, 3, 0, 0, 0, 0, 0, 0, 2));
        vecs.push_back(idle(0, 1, 0, 2));
        vecs.push_back(mk(1, 1, 1, 0, 0, 2, 0, 1, 0, 0, 0, 0, 0, 0, 2));
        vecs.push_back(mk(1, 1, 0, 0, 1, 0, 0, 3, 0, 0, 0, 0, 0, 0, 2));
        vecs.push_back(idle(0, 0, 0, 2));
        // flushed producer
        vecs.push_back(mk(1, 1, 0, 0, 4, 6, 7, 3, 1, 0, 0, 0, 0, 0, 2));
        vecs.push_back(mk(1, 1, 0, 0, 14, 4, 4, 3, 0, 0, 0, 0, 0, 0, 2));
        vecs.push_back(idle(0, 0, 0, 2));
        // flush with stall: no count
        vecs.push_back(mk(1, 1, 1, 0, 5, 2, 0, 1, 0, 0, 0, 0, 0, 0, 2));
        vecs.push_back(mk(1, 1, 0, 0, 11, 5, 0, 1, 1, 0, 1, 0, 0, 0, 2));
        vecs.push_back(idle(0, 0, 0, 2));
        // freeze over a pending forward
        vecs.push_back(mk(1, 1, 0, 0, 3, 1, 2, 3, 0, 0, 0, 0, 0, 0, 2));
        vecs.push_back(mk(1, 1, 0, 0, 6, 3, 1, 3, 0, 0, 0, 0, 0, 0, 2));
        vecs.push_back(mk(1, 1, 0, 0, 7, 3, 6, 3, 0, 1, 0, 1, 0, 0, 2));
        vecs.push_back(mk(1, 1, 0, 0, 7, 3, 6, 3, 0, 1, 0, 1, 0, 0, 2));
        vecs.push_back(mk(1, 1, 0, 0, 7, 3, 6, 3, 0, 1, 0, 1, 0, 0, 2));
        vecs.push_back(mk(1, 1, 0, 0, 7, 3, 6, 3, 0, 0, 0, 1, 0, 0, 2));
        vecs.push_back(idle(2, 1, 0, 2));
        // freeze masks a load-use stall
        vecs.push_back(mk(1, 1, 1, 0, 5, 2, 0, 1, 0, 0, 0, 0, 0, 0, 2));
        vecs.push_back(mk(1, 1, 0, 0, 11, 5, 1, 3, 0, 1, 0, 0, 0, 0, 2));
        vecs.push_back(mk(1, 1, 0, 0, 11, 5, 1, 3, 0, 0, 1, 0, 0, 0, 2));
        vecs.push_back(mk(1, 1, 0, 0, 11, 5, 1, 3, 0, 0, 0, 0, 0, 0, 3));
        vecs.push_back(idle(2, 0, 0, 3));
        // youngest producer wins; disabled sources ignored
        vecs.push_back(mk(1, 1, 0, 0, 3, 1, 2, 3, 0, 0, 0, 0, 0, 0, 3));
        vecs.push_back(mk(1, 1, 0, 0, 3, 3, 2, 3, 0, 0, 0, 0, 0, 0, 3));
        vecs.push_back(mk(1, 1, 0, 0, 9, 3, 3, 3, 0, 0, 0, 1, 0, 0, 3));
        vecs.push_back(idle(1, 1, 0, 3));
        vecs.push_back(mk(1, 1, 0, 0, 10, 9, 9, 0, 0, 0, 0, 0, 0, 0, 3));
        vecs.push_back(idle(0, 0, 0, 3));

        drive(idle(0, 0, 0, 0));
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i]);
            #1;
            checkRow(i, vecs[i]);
        end

        // reset in mid-flight drops the pending producer
        add3 = mk(1, 1, 0, 0, 3, 1, 2, 3, 0, 0, 0, 0, 0, 0, 0);
        rd3  = mk(1, 1, 0, 0, 9, 3, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        drive(add3);
        @(negedge clk);
        drive(rd3);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst sel", 32'(fwd_sel), 32'd0);
        check("rst mem", 32'(fwd_mem), 32'd0);
        check("rst cnt", 32'(stall_cnt), 32'd0);
        check("rst stall", 32'(stall_id), 32'd0);
        @(negedge clk);
        drive(idle(0, 0, 0, 0));
        #1;
        check("post rst sel", 32'(fwd_sel), 32'd0);

        // counter saturation
        lw  = mk(1, 1, 1, 0, 5, 2, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        sub = mk(1, 1, 0, 0, 11, 5, 1, 3, 0, 0, 0, 0, 0, 0, 0);
        for (int n = 1; n <= 65538; n++) begin
            @(negedge clk);
            drive(lw);
            @(negedge clk);
            drive(sub);
            if (n == 1) begin
                #1;
                check("sat first stall", 32'(stall_id), 32'd1);
            end else if (n == 65535) begin
                #1;
                check("sat cnt FFFE", 32'(stall_cnt), 32'hFFFE);
            end else if (n == 65536) begin
                #1;
                check("sat cnt FFFF", 32'(stall_cnt), 32'hFFFF);
            end
        end
        @(negedge clk);
        drive(idle(0, 0, 0, 0));
        #1;
        check("sat hold", 32'(stall_cnt), 32'hFFFF);
        check("sat idle stall", 32'(stall_id), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
